// File: rtl/game_round_ctrl.sv
// Round sequencer for the target-shooting game: launches rounds, judges shots, keeps score.
// Optional build macro HIT_TOLERANCE_EN widens the hit test to +/-TOL grid units per axis.
module game_round_ctrl #(
  parameter int ROUNDS      = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int GAP_CYC     = 4,
  parameter int TOL         = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       start_btn,
  input  logic       fire,
  input  logic [4:0] shot_x,
  input  logic [4:0] shot_y,
  input  logic [4:0] target_x,
  input  logic [4:0] target_y,
  output logic       start_new_game,
  output logic       result_valid,
  output logic       hit,
  output logic [3:0] score,
  output logic [3:0] round_num,
  output logic       busy,
  output logic       game_over
);

  if (ROUNDS < 1 || ROUNDS > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535 ||
      GAP_CYC < 1 || GAP_CYC > 255 || TOL < 0 || TOL > 31) begin : g_bad_cfg
    $error("game_round_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_AIM, S_EVAL, S_SHOW, S_OVER
  } state_t;

`ifdef HIT_TOLERANCE_EN
  function automatic logic [5:0] abs_diff(input logic [4:0] a, input logic [4:0] b);
    logic signed [5:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  function automatic logic is_hit(input logic [4:0] sx, input logic [4:0] sy,
                                  input logic [4:0] tx, input logic [4:0] ty);
    return (abs_diff(sx, tx) <= 6'(TOL)) && (abs_diff(sy, ty) <= 6'(TOL));
  endfunction
`else
  function automatic logic is_hit(input logic [4:0] sx, input logic [4:0] sy,
                                  input logic [4:0] tx, input logic [4:0] ty);
    return (sx == tx) && (sy == ty);
  endfunction
`endif

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  gap_q, gap_d;
  logic [3:0]  score_q, score_d;
  logic [3:0]  round_q, round_d;
  logic        hit_q, hit_d;
  logic        rv_q, rv_d;
  logic        launch_q, launch_d;
  logic        busy_q, busy_d;
  logic        over_q, over_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    score_d = score_q;
    round_d = round_q;
    hit_d   = hit_q;
    rv_d    = rv_q;
    if (ena) begin
      rv_d = 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_btn) begin
            score_d = '0;
            round_d = '0;
            state_d = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          timer_d = '0;
          state_d = S_AIM;
        end
        S_AIM: begin
          timer_d = timer_q + 16'd1;
          // The target is stable for the whole AIM window, so judging the shot as it is
          // accepted gives the same verdict as judging a latched copy one cycle later.
          if (fire) begin
            hit_d   = is_hit(shot_x, shot_y, target_x, target_y);
            rv_d    = 1'b1;
            state_d = S_EVAL;
          end else if (timer_q == 16'(TIMEOUT_CYC - 1)) begin
            hit_d   = 1'b0;
            rv_d    = 1'b1;
            gap_d   = '0;
            state_d = S_SHOW;
          end
        end
        S_EVAL: begin
          if (hit_q && score_q != 4'hF) score_d = score_q + 4'd1;
          gap_d   = '0;
          state_d = S_SHOW;
        end
        S_SHOW: begin
          gap_d = gap_q + 8'd1;
          if (gap_q == 8'(GAP_CYC - 1)) begin
            if (round_q == 4'(ROUNDS - 1)) begin
              state_d = S_OVER;
            end else begin
              round_d = round_q + 4'd1;
              state_d = S_LAUNCH;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    launch_d = (state_d == S_LAUNCH);
    busy_d   = (state_d != S_IDLE) && (state_d != S_OVER);
    over_d   = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      gap_q    <= '0;
      score_q  <= '0;
      round_q  <= '0;
      hit_q    <= 1'b0;
      rv_q     <= 1'b0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
      score_q  <= score_d;
      round_q  <= round_d;
      hit_q    <= hit_d;
      rv_q     <= rv_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
    end
  end

  // Strobes stay pending in their flops while ena is low and are only shown on enabled cycles.
  assign start_new_game = launch_q & ena;
  assign result_valid   = rv_q & ena;
  assign hit            = hit_q;
  assign score          = score_q;
  assign round_num      = round_q;
  assign busy           = busy_q;
  assign game_over      = over_q;

endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round sequencer for the target-shooting game. It starts a game on a button press and requests a fresh target from the target generator each round. It then waits for a player shot or a timeout, judges hit/miss against the current target and pulses the result back to the generator. Score and round count are kept, and the block ends the game after a fixed number of rounds. It sits between the player-input logic and the target generator; its outputs also feed the display/score logic.

## Interface
Parameters:
- ROUNDS, 8, rounds per game; legal range 1..15.
- TIMEOUT_CYC, 1000, AIM-window length in enabled cycles; legal range 1..65535.
- GAP_CYC, 4, enabled cycles spent in SHOW between rounds; legal range 1..255.
- TOL, 1, hit tolerance per axis in grid units; used only with HIT_TOLERANCE_EN; legal range 0..31.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- ena  in  1  global enable; when low, all state is frozen.
- start_btn  in  1  level; starts a game from IDLE or OVER.
- fire  in  1  one-cycle shot strobe.
- shot_x, shot_y  in  5 each  shot coordinates, sampled when fire is accepted.
- target_x, target_y  in  5 each  current target from the target generator.
- start_new_game  out  1  one-cycle request for a new target.
- result_valid  out  1  one-cycle strobe: hit/miss verdict is valid.
- hit  out  1  verdict of the last round; held until the next verdict.
- score  out  4  number of hits in the current game.
- round_num  out  4  index of the current round, 0-based.
- busy  out  1  high in every state except IDLE and OVER.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, LAUNCH, AIM, EVAL, SHOW, OVER. All transitions and counters advance only on cycles with ena=1.
- IDLE: on start_btn=1, clear score and round_num, then go to LAUNCH.
- LAUNCH: assert start_new_game=1 for one cycle; clear the AIM timer; go to AIM.
- AIM:
  - The timer increments every enabled cycle.
  - fire=1 latches shot_x/shot_y into internal registers and moves to EVAL.
  - If the timer reaches TIMEOUT_CYC-1 with fire=0, the round is a miss: result_valid=1 and hit=0 on the exit cycle, then go to SHOW.
  - fire on the same cycle as the timeout cycle counts as a shot (fire wins).
- EVAL: compare the latched shot to target_x/target_y. On the same cycle, assert result_valid=1, register hit, and increment score if hit (saturate at 15). Go to SHOW.
- SHOW: wait GAP_CYC cycles. Then:
  - if round_num==ROUNDS-1, go to OVER;
  - otherwise increment round_num and go to LAUNCH.
- OVER: game_over=1; score and hit are held. start_btn=1 clears score and round_num and goes to LAUNCH.
- start_btn is ignored in every state except IDLE and OVER. fire is ignored outside AIM.
- Hit compare: difference computed as 6-bit signed |shot−target| per axis, with no wrap-around; coordinate 0 and coordinate 31 are 31 apart.

## Timing
- Reset values:
  - state IDLE;
  - start_new_game=0, result_valid=0, hit=0;
  - score=0, round_num=0;
  - busy=0, game_over=0.
- Reset applied mid-game returns to IDLE on the next edge; it overrides ena.
- All outputs are registered.
- start_new_game is high exactly one cycle per round. The target generator loads on that edge; target_x/target_y are stable from the first AIM cycle onward.
- Latency:
  - fire accepted in AIM → result_valid 1 cycle later (EVAL cycle);
  - score update is visible on the cycle after result_valid.
- Exactly one result_valid pulse per round.
- ena=0:
  - start_new_game and result_valid are forced to 0;
  - state, timer and GAP counter hold;
  - the pending pulse is issued on the first cycle with ena=1.
- Minimum round length with an immediate fire: 1 (LAUNCH) + 1 (AIM) + 1 (EVAL) + GAP_CYC cycles.

## Configuration
- HIT_TOLERANCE_EN defined: hit = (|dx|≤TOL) && (|dy|≤TOL).
- HIT_TOLERANCE_EN undefined:
  - hit = exact match on both axes;
  - TOL is unused and its compare logic is not built.

## Test plan
- Reset, then start_btn pulse → start_new_game high exactly 1 cycle, then busy=1 and round_num=0.
- Target (12,30), fire at (12,30) → result_valid with hit=1 one cycle after fire; score 0→1.
- Target (12,30), fire at (13,31):
  - without HIT_TOLERANCE_EN → hit=0;
  - with HIT_TOLERANCE_EN and TOL=1 → hit=1;
  - shot at (14,30) → hit=0 in both builds.
- No fire, TIMEOUT_CYC=10 → result_valid and hit=0 exactly 10 enabled cycles after LAUNCH; fire on cycle 10 instead → treated as a shot.
- ROUNDS=3, all hits → game_over=1, score=3, 3 start_new_game pulses in total; start_btn in OVER → score=0 and a new LAUNCH.
- ena held low for 5 cycles during LAUNCH, then reset asserted during AIM → no pulse while ena=0, one pulse after ena returns; reset → IDLE with all outputs at reset values.
